bus_mem_responder: RTL and testbench



---
 rtl/bus_pkg.sv | 43 ++++
 rtl/amo_alu.sv | 27 ++
 rtl/bus_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_bus_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus field widths, AMO funct5 codes and responder encodings
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int OP_W   = 7;
    localparam int BE_W   = 4;
    localparam int F5_W   = 5;

    localparam logic [F5_W-1:0] AMO_ADD  = 5'b00000;
    localparam logic [F5_W-1:0] AMO_SWAP = 5'b00001;
    localparam logic [F5_W-1:0] AMO_LR   = 5'b00010;
    localparam logic [F5_W-1:0] AMO_SC   = 5'b00011;
    localparam logic [F5_W-1:0] AMO_XOR  = 5'b00100;
    localparam logic [F5_W-1:0] AMO_OR   = 5'b01000;
    localparam logic [F5_W-1:0] AMO_AND  = 5'b01100;
    localparam logic [F5_W-1:0] AMO_MIN  = 5'b10000;
    localparam logic [F5_W-1:0] AMO_MAX  = 5'b10100;
    localparam logic [F5_W-1:0] AMO_MINU = 5'b11000;
    localparam logic [F5_W-1:0] AMO_MAXU = 5'b11100;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_AMO_WR, S_ACK} resp_state_t;
    typedef enum logic [2:0] {K_READ, K_WRITE, K_LR, K_SC, K_AMO} req_kind_t;

    function automatic logic is_amo_rmw(input logic [F5_W-1:0] f5);
        case (f5)
            AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    // Unknown atomic codes fall back to a plain read.
    function automatic req_kind_t decode_kind(input logic atomic, input logic wr,
                                              input logic [F5_W-1:0] f5);
        if (!atomic)         return wr ? K_WRITE : K_READ;
        if (f5 == AMO_LR)    return K_LR;
        if (f5 == AMO_SC)    return K_SC;
        if (is_amo_rmw(f5))  return K_AMO;
        return K_READ;
    endfunction

endpackage

// File: rtl/amo_alu.sv
// rtl/amo_alu.sv - combinational AMO read-modify-write datapath
module amo_alu
    import bus_pkg::*;
(
    input  logic [F5_W-1:0]   funct5,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] new_word
);

    always_comb begin
        new_word = old_word;
        case (funct5)
            AMO_SWAP: new_word = operand;
            AMO_ADD:  new_word = old_word + operand;
            AMO_XOR:  new_word = old_word ^ operand;
            AMO_AND:  new_word = old_word & operand;
            AMO_OR:   new_word = old_word | operand;
            AMO_MIN:  new_word = ($signed(old_word) < $signed(operand)) ? old_word : operand;
            AMO_MAX:  new_word = ($signed(old_word) > $signed(operand)) ? old_word : operand;
            AMO_MINU: new_word = (old_word < operand) ? old_word : operand;
            AMO_MAXU: new_word = (old_word > operand) ? old_word : operand;
            default:  new_word = old_word;
        endcase
    end

endmodule

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - bus target with word memory, byte writes, LR/SC and AMOs
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bus_en,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [BE_W-1:0]   i_byte_en,
    input  logic              i_atomic,
    input  logic [OP_W-1:0]   i_operation,
    input  logic              i_id,
    output logic              o_ack,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    resp_state_t       state, next_state;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q, old_q;
    logic [BE_W-1:0]   be_q;
    logic              atomic_q, wr_q, id_q, sc_fail_q;
    logic [F5_W-1:0]   f5_q;
    logic [3:0]        cnt;
    logic [1:0]        res_v;
    logic [AW-1:0]     res_idx [2];

    // In IDLE the live request is used so zero-latency commits need no extra cycle.
    logic              in_idle, accept, commit, sc_ok;
    logic [AW-1:0]     cur_idx;
    logic [DATA_W-1:0] cur_wdata, amo_new, mem_wdata;
    logic [BE_W-1:0]   cur_be, mem_be;
    logic              cur_atomic, cur_wr, cur_id, mem_we;
    logic [F5_W-1:0]   cur_f5;
    req_kind_t         cur_kind;
    logic              unused_bits;

    assign in_idle    = (state == S_IDLE);
    assign accept     = in_idle && i_bus_en;
    assign cur_idx    = in_idle ? i_addr[AW+1:2]     : idx_q;
    assign cur_wdata  = in_idle ? i_wr_data          : wdata_q;
    assign cur_be     = in_idle ? i_byte_en          : be_q;
    assign cur_atomic = in_idle ? i_atomic           : atomic_q;
    assign cur_wr     = in_idle ? i_wr_en            : wr_q;
    assign cur_id     = in_idle ? i_id               : id_q;
    assign cur_f5     = in_idle ? i_operation[6:2]   : f5_q;
    assign cur_kind   = decode_kind(cur_atomic, cur_wr, cur_f5);
    assign sc_ok      = res_v[cur_id] && (res_idx[cur_id] == cur_idx);
    assign unused_bits = &{1'b0, i_addr[ADDR_W-1:AW+2], i_addr[1:0], i_operation[1:0]};

    amo_alu u_amo_alu (
        .funct5   (cur_f5),
        .old_word (old_q),
        .operand  (cur_wdata),
        .new_word (amo_new)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (i_bus_en) begin
                if (LATENCY > 0)           next_state = S_WAIT;
                else if (cur_kind == K_AMO) next_state = S_AMO_WR;
                else                       next_state = S_ACK;
            end
            S_WAIT:   if (cnt == 4'd0) next_state = (cur_kind == K_AMO) ? S_AMO_WR : S_ACK;
            S_AMO_WR: next_state = S_ACK;
            S_ACK:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_ack     = (state == S_ACK);
        o_rd_data = '0;
        if (state == S_ACK) begin
            case (cur_kind)
                K_WRITE: o_rd_data = '0;
                K_SC:    o_rd_data = DATA_W'(sc_fail_q);
                default: o_rd_data = old_q;
            endcase
        end
    end

    // Every memory update lands on the edge that enters ACK.
    assign commit = (state != S_ACK) && (next_state == S_ACK);

    always_comb begin
        mem_be    = '0;
        mem_wdata = cur_wdata;
        if (commit) begin
            case (cur_kind)
                K_WRITE: mem_be = cur_be;
                K_SC:    if (sc_ok) mem_be = '1;
                K_AMO:   begin mem_be = '1; mem_wdata = amo_new; end
                default: mem_be = '0;
            endcase
        end
        mem_we = |mem_be;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int b = 0; b < BE_W; b++)
                if (mem_be[b]) mem[cur_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q     <= '0;
            wdata_q   <= '0;
            old_q     <= '0;
            be_q      <= '0;
            atomic_q  <= 1'b0;
            wr_q      <= 1'b0;
            id_q      <= 1'b0;
            f5_q      <= '0;
            sc_fail_q <= 1'b0;
            cnt       <= '0;
            res_v     <= '0;
            for (int i = 0; i < 2; i++) res_idx[i] <= '0;
        end else begin
            if (accept) begin
                idx_q    <= cur_idx;
                wdata_q  <= i_wr_data;
                be_q     <= i_byte_en;
                atomic_q <= i_atomic;
                wr_q     <= i_wr_en;
                id_q     <= i_id;
                f5_q     <= i_operation[6:2];
                old_q    <= mem[cur_idx];
                cnt      <= (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                for (int i = 0; i < 2; i++)
                    if (mem_we && res_idx[i] == cur_idx) res_v[i] <= 1'b0;
                if (cur_kind == K_LR) begin
                    res_v[cur_id]   <= 1'b1;
                    res_idx[cur_id] <= cur_idx;
                end
                if (cur_kind == K_SC) begin
                    res_v[cur_id] <= 1'b0;
                    sc_fail_q     <= !sc_ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - scoreboard bench with a behavioural memory/reservation model
module tb_bus_mem_responder;
    import bus_pkg::*;

    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_en = 1'b0, wr_en = 1'b0, atomic = 1'b0, id = 1'b0;
    logic [31:0] addr = '0, wr_data = '0;
    logic [3:0]  byte_en = '0;
    logic [6:0]  operation = '0;
    logic        ack;
    logic [31:0] rd_data;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mem_m [1024];
    bit   [1:0]  res_v_m = '0;
    int          res_idx_m [2];
    int          pool [8] = '{4, 8, 16, 32, 5, 100, 1023, 511};

    always #5 clk = ~clk;

    bus_mem_responder #(.DEPTH(1024), .AW(10), .LATENCY(L)) dut (
        .i_clk(clk), .i_rst(rst), .i_bus_en(bus_en), .i_wr_en(wr_en), .i_addr(addr),
        .i_wr_data(wr_data), .i_byte_en(byte_en), .i_atomic(atomic),
        .i_operation(operation), .i_id(id), .o_ack(ack), .o_rd_data(rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got ack with rd_data %h, expected no ack at %0t", rd_data, $time);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic kill(input int idx);
        for (int i = 0; i < 2; i++)
            if (res_v_m[i] && res_idx_m[i] == idx) res_v_m[i] = 1'b0;
    endtask

    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit at, input logic [4:0] f5, input bit who,
                         output logic [31:0] rd, output int lat);
        int          idx;
        logic [31:0] old, nw;
        bit          wrote, amo, ok;
        idx = int'(a[11:2]);
        old = mem_m[idx];
        nw = old; rd = old; lat = L + 1; wrote = 0; amo = 0;
        if (!at) begin
            if (w) begin
                rd = 0;
                for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
                wrote = (be != 4'b0000);
            end
        end else begin
            case (f5)
                AMO_LR: begin res_v_m[who] = 1'b1; res_idx_m[who] = idx; end
                AMO_SC: begin
                    ok = res_v_m[who] && res_idx_m[who] == idx;
                    res_v_m[who] = 1'b0;
                    rd = ok ? 32'd0 : 32'd1;
                    if (ok) begin nw = d; wrote = 1; end
                end
                AMO_SWAP: begin nw = d; amo = 1; end
                AMO_ADD:  begin nw = old + d; amo = 1; end
                AMO_XOR:  begin nw = old ^ d; amo = 1; end
                AMO_AND:  begin nw = old & d; amo = 1; end
                AMO_OR:   begin nw = old | d; amo = 1; end
                AMO_MIN:  begin nw = ($signed(old) < $signed(d)) ? old : d; amo = 1; end
                AMO_MAX:  begin nw = ($signed(old) > $signed(d)) ? old : d; amo = 1; end
                AMO_MINU: begin nw = (old < d) ? old : d; amo = 1; end
                AMO_MAXU: begin nw = (old > d) ? old : d; amo = 1; end
                default: ;
            endcase
        end
        if (amo) begin wrote = 1; lat = L + 2; end
        if (wrote) begin mem_m[idx] = nw; kill(idx); end
    endtask

    task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit at, input logic [4:0] f5, input bit who);
        bus_en = 1'b1; wr_en = w; addr = a; wr_data = d; byte_en = be;
        atomic = at; operation = {f5, 2'($urandom)}; id = who;
    endtask

    // Inputs are scrambled after acceptance: the transaction must run on latched fields.
    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit at, input logic [4:0] f5, input bit who);
        logic [31:0] rd;
        int lat, n;
        bit got;
        model(w, a, d, be, at, f5, who, rd, lat);
        exp_q.push_back(rd);
        @(negedge clk);
        drive(w, a, d, be, at, f5, who);
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                addr = $urandom; wr_data = $urandom; byte_en = 4'($urandom);
                wr_en = 1'($urandom); atomic = 1'($urandom); operation = 7'($urandom);
                id = 1'($urandom); bus_en = 1'($urandom);
            end
            if (ack === 1'b1) got = 1;
        end
        bus_en = 1'b0;
        check("latency", n, lat);
        if (got) @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected completion before %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [4:0]  f5_tab [14];
        int lat, acks, last, cyc, idx, r;
        f5_tab = '{AMO_LR, AMO_LR, AMO_SC, AMO_SC, AMO_ADD, AMO_SWAP, AMO_XOR,
                   AMO_AND, AMO_OR, AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU, 5'b00101};
        res_idx_m = '{0, 0};

        #1;
        check("reset_ack", {31'b0, ack}, 0);
        check("reset_rd_data", rd_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int p = 0; p < 8; p++) txn(1, pool[p] << 2, $urandom, 4'hF, 0, 0, 0);

        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        txn(0, 32'h10, 0, 4'h0, 0, 0, 0);
        txn(1, 32'h20, 32'h11223344, 4'hF, 0, 0, 0);
        txn(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        txn(0, 32'h20, 0, 4'h0, 0, 0, 0);
        txn(0, 32'h40, 0, 4'h0, 1, AMO_LR, 0);
        txn(0, 32'h40, 7, 4'h0, 1, AMO_SC, 0);
        txn(0, 32'h40, 0, 4'h0, 0, 0, 0);
        txn(0, 32'h40, 9, 4'h0, 1, AMO_SC, 0);
        txn(0, 32'h40, 0, 4'h0, 0, 0, 0);
        txn(0, 32'h80, 0, 4'h0, 1, AMO_LR, 0);
        txn(1, 32'h80, 32'h12345678, 4'hF, 0, 0, 1);
        txn(0, 32'h80, 3, 4'h0, 1, AMO_SC, 0);
        txn(0, 32'h80, 0, 4'h0, 0, 0, 0);
        txn(1, 32'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        txn(0, 32'h10, 2, 4'h0, 1, AMO_ADD, 0);
        txn(0, 32'h10, 0, 4'h0, 0, 0, 0);
        txn(1, 32'h10, 32'hFFFFFFFE, 4'hF, 0, 0, 0);
        txn(0, 32'h10, 5, 4'h0, 1, AMO_MIN, 1);
        txn(0, 32'h10, 5, 4'h0, 1, AMO_MINU, 1);
        txn(0, 32'h10, 0, 4'h0, 0, 0, 0);
        txn(1, 32'h10 | 32'h0000_1003, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        txn(1, 32'h10, 32'h0BADF00D, 4'h0, 0, 0, 0);
        txn(0, 32'hFFFF_F010, 0, 4'h0, 0, 0, 0);
        txn(0, 32'h10, 32'h55, 4'h0, 1, 5'b00101, 0);

        // Reset asserted while the AMO is in its write state.
        txn(0, 32'h40, 0, 4'h0, 1, AMO_LR, 0);
        @(negedge clk);
        drive(0, 32'h40, 32'h99, 4'h0, 1, AMO_SWAP, 0);
        @(posedge clk); #1; bus_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ack", {31'b0, ack}, 0);
        check("rst_mid_rd_data", rd_data, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        res_v_m = '0;
        txn(0, 32'h40, 32'h77, 4'h0, 1, AMO_SC, 0);
        txn(0, 32'h40, 0, 4'h0, 0, 0, 0);

        // Request held across ACK: one acceptance per transaction.
        for (int k = 0; k < 4; k++) begin
            model(0, 32'h20, 0, 4'h0, 0, 0, 0, rd, lat);
            exp_q.push_back(rd);
        end
        @(negedge clk);
        drive(0, 32'h20, 0, 4'h0, 0, 0, 0);
        acks = 0; last = -1; cyc = 0;
        while (acks < 4 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (ack === 1'b1) begin
                acks++;
                if (last >= 0) check("b2b_spacing", cyc - last, L + 2);
                last = cyc;
            end
        end
        bus_en = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        check("b2b_acks", acks, 4);

        for (int t = 0; t < 300; t++) begin
            idx = pool[$urandom_range(0, 7)];
            addr = ($urandom & 32'hFFFF_F003) | (idx << 2);
            r = $urandom_range(0, 5);
            if (r == 0)      txn(0, addr, $urandom, 4'($urandom), 0, 0, 1'($urandom));
            else if (r == 1) txn(1, addr, $urandom, 4'($urandom), 0, 0, 1'($urandom));
            else             txn(1'($urandom), addr, $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom,
                                 4'($urandom), 1, f5_tab[$urandom_range(0, 13)], 1'($urandom));
        end

        repeat (5) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
